// File: rtl/cmd_router_pkg.sv
// cmd_router_pkg: types, defaults and helpers shared by the command router.
//   state_t          - router FSM states (IDLE, WAIT_ACK, RESP)
//   ERR_DATA_DEFAULT - read data returned when a command is unmapped or times out
//   port_index()     - extracts the downstream port index from a byte address
package cmd_router_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD0_C0DE;

  // The port index is the top sel_bits bits of an addr_bits-wide address.
  // The address is passed zero-extended to 32 bits so that one function
  // serves every parameterisation.
  function automatic logic [31:0] port_index(input logic [31:0] addr,
                                             input int addr_bits,
                                             input int sel_bits);
    logic [31:0] mask;
    mask = (32'd1 << sel_bits) - 32'd1;
    return (addr >> (addr_bits - sel_bits)) & mask;
  endfunction

endpackage

// File: rtl/sat_cnt8.sv
// sat_cnt8: 8-bit event counter that sticks at 255 instead of wrapping.
//   clk   - clock, rising edge
//   arst  - asynchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   count - current count
module sat_cnt8 (
  input  logic       clk,
  input  logic       arst,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_reg <= 8'd0;
    end else if (inc && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cmd_router.sv
// cmd_router: routes one upstream command at a time to one of NUM_SLAVES
// downstream ports, selected by the upper SEL_BITS address bits, and returns
// the slave response (or ERR_DATA on unmapped port / ack timeout).
//   i_sys_clk, i_sys_arst          - clock and asynchronous active-high reset
//   cmd_sel, cmd_rd_wr_n,
//   cmd_byte_addr, cmd_wdata       - upstream command request
//   cmd_ack, cmd_rdata             - upstream one-cycle response (rdata 0 when idle)
//   o_sel                          - one-hot one-cycle select pulse to the slaves
//   o_rd_wr_n, o_byte_addr, o_wdata- latched command, address with port bits pruned
//   i_ack, i_rdata                 - per-port ack and read data
//   o_timeout_cnt, o_unmapped_cnt  - saturating error counters
//   o_busy                         - a command is in progress
module cmd_router
  import cmd_router_pkg::*;
#(
  parameter int                  ADDR_BITS      = 24,
  parameter int                  DATA_BITS      = 32,
  parameter int                  NUM_SLAVES     = 4,
  parameter int                  SEL_BITS       = 4,
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_BITS-1:0] ERR_DATA      = DATA_BITS'(ERR_DATA_DEFAULT)
) (
  input  logic                            i_sys_clk,
  input  logic                            i_sys_arst,
  input  logic                            cmd_sel,
  input  logic                            cmd_rd_wr_n,
  input  logic [ADDR_BITS-1:0]            cmd_byte_addr,
  input  logic [DATA_BITS-1:0]            cmd_wdata,
  output logic                            cmd_ack,
  output logic [DATA_BITS-1:0]            cmd_rdata,
  output logic [NUM_SLAVES-1:0]           o_sel,
  output logic                            o_rd_wr_n,
  output logic [ADDR_BITS-SEL_BITS-1:0]   o_byte_addr,
  output logic [DATA_BITS-1:0]            o_wdata,
  input  logic [NUM_SLAVES-1:0]           i_ack,
  input  logic [NUM_SLAVES*DATA_BITS-1:0] i_rdata,
  output logic [7:0]                      o_timeout_cnt,
  output logic [7:0]                      o_unmapped_cnt,
  output logic                            o_busy
);

  localparam int PA_BITS = ADDR_BITS - SEL_BITS;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [TW-1:0]           timer_reg, timer_next;
  logic [NUM_SLAVES-1:0]   mask_reg, mask_next;
  logic [NUM_SLAVES-1:0]   sel_reg, sel_next;
  logic                    rd_wr_n_reg, rd_wr_n_next;
  logic [PA_BITS-1:0]      addr_reg, addr_next;
  logic [DATA_BITS-1:0]    wdata_reg, wdata_next;
  logic [DATA_BITS-1:0]    resp_reg, resp_next;
  logic                    ack_reg, ack_next;
  logic                    timeout_inc, unmapped_inc;

  logic [31:0]             cmd_idx;
  logic                    cmd_mapped;
  logic [NUM_SLAVES-1:0]   idx_onehot;
  logic [DATA_BITS-1:0]    slave_rdata [NUM_SLAVES];
  logic [DATA_BITS-1:0]    sel_rdata;
  logic                    ack_hit;
  logic                    timer_expired;

  assign cmd_idx    = port_index(32'(cmd_byte_addr), ADDR_BITS, SEL_BITS);
  assign cmd_mapped = (cmd_idx < 32'(NUM_SLAVES));

  // Unmapped indices decode to an all-zero mask, so no slave is touched.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_port
    assign idx_onehot[gi]  = (cmd_idx == 32'(gi));
    assign slave_rdata[gi] = i_rdata[gi*DATA_BITS +: DATA_BITS];
  end

  // The latched one-hot mask filters acks from non-selected ports and picks
  // the matching read data slice.
  assign ack_hit = |(mask_reg & i_ack);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (mask_reg[i]) sel_rdata = sel_rdata | slave_rdata[i];
    end
  end

  // Timer is 0 in the o_sel cycle, so it reaches TIMER_LAST in the
  // TIMEOUT_CYCLES-th cycle of waiting; an ack in that cycle still wins.
  assign timer_expired = (timer_reg == TIMER_LAST);

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    mask_next    = mask_reg;
    sel_next     = '0;
    rd_wr_n_next = rd_wr_n_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    resp_next    = resp_reg;
    ack_next     = 1'b0;
    timeout_inc  = 1'b0;
    unmapped_inc = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_sel) begin
          rd_wr_n_next = cmd_rd_wr_n;
          addr_next    = cmd_byte_addr[PA_BITS-1:0];
          wdata_next   = cmd_wdata;
          mask_next    = idx_onehot;
          timer_next   = '0;
          if (cmd_mapped) begin
            sel_next   = idx_onehot;
            state_next = WAIT_ACK;
          end else begin
            resp_next    = ERR_DATA;
            unmapped_inc = 1'b1;
            state_next   = RESP;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_hit) begin
          resp_next  = sel_rdata;
          ack_next   = 1'b1;
          state_next = RESP;
        end else if (timer_expired) begin
          resp_next   = ERR_DATA;
          ack_next    = 1'b1;
          timeout_inc = 1'b1;
          state_next  = RESP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      RESP: begin
        // Mapped paths enter RESP with ack already raised. Unmapped commands
        // arrive without it and spend one extra cycle here raising it, which
        // places their ack two cycles after cmd_sel.
        if (ack_reg) state_next = IDLE;
        else         ack_next   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
    if (i_sys_arst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      mask_reg    <= '0;
      sel_reg     <= '0;
      rd_wr_n_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      resp_reg    <= '0;
      ack_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      mask_reg    <= mask_next;
      sel_reg     <= sel_next;
      rd_wr_n_reg <= rd_wr_n_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      resp_reg    <= resp_next;
      ack_reg     <= ack_next;
    end
  end

  sat_cnt8 u_timeout_cnt (
    .clk   (i_sys_clk),
    .arst  (i_sys_arst),
    .inc   (timeout_inc),
    .count (o_timeout_cnt)
  );

  sat_cnt8 u_unmapped_cnt (
    .clk   (i_sys_clk),
    .arst  (i_sys_arst),
    .inc   (unmapped_inc),
    .count (o_unmapped_cnt)
  );

  assign cmd_ack     = ack_reg;
  assign cmd_rdata   = ack_reg ? resp_reg : '0;
  assign o_sel       = sel_reg;
  assign o_rd_wr_n   = rd_wr_n_reg;
  assign o_byte_addr = addr_reg;
  assign o_wdata     = wdata_reg;
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cmd_router.sv
// tb_cmd_router: directed self-checking bench for cmd_router (default
// parameters). Expected responses are queued when a command is issued and
// popped when cmd_ack is seen.
module tb_cmd_router;

  localparam logic [31:0] ERR = 32'hBAD0_C0DE;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         cmd_sel = 1'b0;
  logic         cmd_rd_wr_n = 1'b0;
  logic [23:0]  cmd_byte_addr = '0;
  logic [31:0]  cmd_wdata = '0;
  logic         cmd_ack;
  logic [31:0]  cmd_rdata;
  logic [3:0]   o_sel;
  logic         o_rd_wr_n;
  logic [19:0]  o_byte_addr;
  logic [31:0]  o_wdata;
  logic [3:0]   i_ack = '0;
  logic [127:0] i_rdata = '0;
  logic [7:0]   o_timeout_cnt;
  logic [7:0]   o_unmapped_cnt;
  logic         o_busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  cmd_router dut (
    .i_sys_clk      (clk),
    .i_sys_arst     (arst),
    .cmd_sel        (cmd_sel),
    .cmd_rd_wr_n    (cmd_rd_wr_n),
    .cmd_byte_addr  (cmd_byte_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_ack        (cmd_ack),
    .cmd_rdata      (cmd_rdata),
    .o_sel          (o_sel),
    .o_rd_wr_n      (o_rd_wr_n),
    .o_byte_addr    (o_byte_addr),
    .o_wdata        (o_wdata),
    .i_ack          (i_ack),
    .i_rdata        (i_rdata),
    .o_timeout_cnt  (o_timeout_cnt),
    .o_unmapped_cnt (o_unmapped_cnt),
    .o_busy         (o_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [23:0] addr, input logic rw, input logic [31:0] wd,
                       input logic [31:0] exp_rdata);
    cmd_sel       = 1'b1;
    cmd_byte_addr = addr;
    cmd_rd_wr_n   = rw;
    cmd_wdata     = wd;
    exp_q.push_back(exp_rdata);
    $display("[TB] issue addr=%06h rw=%0b wdata=%08h exp=%08h", addr, rw, wd, exp_rdata);
  endtask

  task automatic slave_ack(input int port, input logic [31:0] data);
    i_ack = '0;
    i_ack[port] = 1'b1;
    i_rdata[port*32 +: 32] = data;
  endtask

  // Waits for cmd_ack, checks latency (ticks waited) and popped rdata, then
  // checks the ack is a single-cycle pulse with rdata back at 0.
  task automatic wait_resp(input string tag, input int exp_lat);
    int n;
    logic [31:0] exp;
    n = 0;
    while (cmd_ack !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (cmd_ack !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s_ack: observed no ack in %0d cycles, expected ack", tag, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s_sb: observed ack, expected none (queue empty)", tag);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_rdata"}, 64'(cmd_rdata), 64'(exp));
    $display("[TB] resp %s rdata=%08h exp=%08h lat=%0d", tag, cmd_rdata, exp, n);
    tick();
    check({tag, "_pulse"}, 64'(cmd_ack), 64'd0);
    check({tag, "_rdata0"}, 64'(cmd_rdata), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(cmd_ack), 64'd0);
    check({tag, "_rdata"}, 64'(cmd_rdata), 64'd0);
    check({tag, "_sel"}, 64'(o_sel), 64'd0);
    check({tag, "_rw"}, 64'(o_rd_wr_n), 64'd0);
    check({tag, "_addr"}, 64'(o_byte_addr), 64'd0);
    check({tag, "_wdata"}, 64'(o_wdata), 64'd0);
    check({tag, "_tocnt"}, 64'(o_timeout_cnt), 64'd0);
    check({tag, "_umcnt"}, 64'(o_unmapped_cnt), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    // Reset state
    tick();
    check_all_zero("reset");
    arst = 1'b0;
    tick();

    // Mapped read to port 2; slave acks 3 cycles after o_sel
    issue(24'h20_0010, 1'b1, 32'h0, 32'h1234_5678);
    tick();
    cmd_sel = 1'b0;
    check("rd_sel", 64'(o_sel), 64'h4);
    check("rd_addr", 64'(o_byte_addr), 64'h0_0010);
    check("rd_rw", 64'(o_rd_wr_n), 64'd1);
    check("rd_busy", 64'(o_busy), 64'd1);
    tick();
    check("rd_sel_pulse", 64'(o_sel), 64'h0);
    check("rd_addr_hold", 64'(o_byte_addr), 64'h0_0010);
    tick();
    slave_ack(2, 32'h1234_5678);
    tick();
    i_ack = '0;
    wait_resp("rd", 0);

    // Write to port 0; write also returns slave rdata
    issue(24'h00_0004, 1'b0, 32'hCAFE_F00D, 32'h0000_AAAA);
    tick();
    cmd_sel = 1'b0;
    check("wr_sel", 64'(o_sel), 64'h1);
    check("wr_wdata", 64'(o_wdata), 64'hCAFE_F00D);
    check("wr_rw", 64'(o_rd_wr_n), 64'd0);
    slave_ack(0, 32'h0000_AAAA);
    tick();
    i_ack = '0;
    check("wr_wdata_hold", 64'(o_wdata), 64'hCAFE_F00D);
    wait_resp("wr", 0);

    // Unmapped access: no o_sel, ack two cycles after sel
    issue(24'h50_0000, 1'b1, 32'h0, ERR);
    tick();
    cmd_sel = 1'b0;
    check("um_sel", 64'(o_sel), 64'h0);
    check("um_busy", 64'(o_busy), 64'd1);
    wait_resp("um", 1);
    check("um_cnt", 64'(o_unmapped_cnt), 64'd1);

    // Timeout on port 1: ack 1024 cycles after o_sel
    issue(24'h10_0000, 1'b1, 32'h0, ERR);
    tick();
    cmd_sel = 1'b0;
    check("to_sel", 64'(o_sel), 64'h2);
    wait_resp("to", 1024);
    check("to_cnt", 64'(o_timeout_cnt), 64'd1);
    // Late ack in IDLE is ignored
    slave_ack(1, 32'hDEAD_0001);
    tick();
    i_ack = '0;
    check("late_busy", 64'(o_busy), 64'd0);
    check("late_ack", 64'(cmd_ack), 64'd0);
    tick();
    check("late_ack2", 64'(cmd_ack), 64'd0);
    check("late_tocnt", 64'(o_timeout_cnt), 64'd1);

    // Ack exactly at expiry counts as success
    issue(24'h10_0020, 1'b1, 32'h0, 32'h5A5A_0001);
    tick();
    cmd_sel = 1'b0;
    for (int i = 0; i < 1023; i++) tick();
    slave_ack(1, 32'h5A5A_0001);
    tick();
    i_ack = '0;
    wait_resp("edge", 0);
    check("edge_tocnt", 64'(o_timeout_cnt), 64'd1);

    // Wrong-port ack and busy sel while waiting on port 3
    issue(24'h30_0000, 1'b1, 32'h0, 32'h3333_0003);
    tick();
    cmd_sel = 1'b0;
    check("wp_sel", 64'(o_sel), 64'h8);
    tick();
    slave_ack(1, 32'h1111_1111);
    cmd_sel = 1'b1;
    cmd_byte_addr = 24'h00_0000;
    tick();
    i_ack = '0;
    cmd_sel = 1'b0;
    check("wp_noack", 64'(cmd_ack), 64'd0);
    check("wp_nosel", 64'(o_sel), 64'h0);
    check("wp_busy", 64'(o_busy), 64'd1);
    check("wp_addr", 64'(o_byte_addr), 64'h0_0000);
    tick();
    slave_ack(3, 32'h3333_0003);
    tick();
    i_ack = '0;
    wait_resp("wp", 0);
    tick();
    check("wp_idle_sel", 64'(o_sel), 64'h0);
    check("wp_idle_busy", 64'(o_busy), 64'd0);
    check("wp_idle_ack", 64'(cmd_ack), 64'd0);

    // Reset in WAIT_ACK: outputs clear immediately, no ack afterwards
    issue(24'h20_0040, 1'b0, 32'h7777_7777, 32'h0);
    void'(exp_q.pop_back());
    tick();
    cmd_sel = 1'b0;
    tick();
    check("rst_pre_busy", 64'(o_busy), 64'd1);
    arst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    tick();
    arst = 1'b0;
    slave_ack(2, 32'h2222_2222);
    tick();
    i_ack = '0;
    check("rst_late_ack", 64'(cmd_ack), 64'd0);
    check("rst_late_busy", 64'(o_busy), 64'd0);
    // First command after reset is accepted normally
    issue(24'h00_0100, 1'b1, 32'h0, 32'h0BAD_F00D);
    tick();
    cmd_sel = 1'b0;
    check("post_rst_sel", 64'(o_sel), 64'h1);
    slave_ack(0, 32'h0BAD_F00D);
    tick();
    i_ack = '0;
    wait_resp("post_rst", 0);

    // Unmapped counter saturation
    for (int i = 0; i < 300; i++) begin
      issue(24'hF0_0000 | 24'(i), 1'b1, 32'h0, ERR);
      tick();
      cmd_sel = 1'b0;
      wait_resp("sat", 1);
      if (i == 254) check("sat_255", 64'(o_unmapped_cnt), 64'd255);
    end
    check("sat_final", 64'(o_unmapped_cnt), 64'd255);
    check("sat_tocnt", 64'(o_timeout_cnt), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmd_router.md
CMD_ROUTER -- requirements
Module: cmd_router

Interface
REQ-001 Parameters: ADDR_BITS=24, byte-address width of the upstream command; DATA_BITS=32, data width; NUM_SLAVES=4, downstream ports (1..16); SEL_BITS=4, upper address bits selecting the port; TIMEOUT_CYCLES=1024, wait-for-ack limit; ERR_DATA=32'hBAD0_C0DE, rdata returned on error.
REQ-002 Ports:
- i_sys_clk  in  1  system clock, all logic on rising edge.
- i_sys_arst  in  1  asynchronous, active-high reset.
- cmd_in  intf_cmd.slave  -  upstream command port: sel, rd_wr_n, byte_addr[ADDR_BITS], wdata, ack, rdata.
- o_sel  out  NUM_SLAVES  one-hot per-port select pulse.
- o_rd_wr_n  out  1  latched read/write-not flag.
- o_byte_addr  out  ADDR_BITS-SEL_BITS  latched address with the SEL_BITS upper bits pruned.
- o_wdata  out  DATA_BITS  latched write data.
- i_ack  in  NUM_SLAVES  per-port one-cycle ack.
- i_rdata  in  NUM_SLAVES*DATA_BITS  per-port read data; port n occupies bits [n*DATA_BITS +: DATA_BITS].
- o_timeout_cnt  out  8  saturating count of timed-out transactions.
- o_unmapped_cnt  out  8  saturating count of accesses to unmapped ports.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 Port index is byte_addr[ADDR_BITS-1 -: SEL_BITS]; an index >= NUM_SLAVES is unmapped.
REQ-004 FSM states: IDLE, WAIT_ACK, RESP.
REQ-005 IDLE with cmd_in.sel=1: latch rd_wr_n, pruned address, wdata and index. Mapped index: next state WAIT_ACK. Unmapped index: next state RESP with response data ERR_DATA, and o_unmapped_cnt increments.
REQ-006 On entry to WAIT_ACK, o_sel[index] is asserted for exactly one cycle, in the cycle after cmd_in.sel. o_rd_wr_n, o_byte_addr and o_wdata stay stable from that cycle until the FSM returns to IDLE.
REQ-007 WAIT_ACK: on i_ack[index]=1, capture the selected slice of i_rdata and go to RESP. i_ack bits of non-selected ports are ignored.
REQ-008 WAIT_ACK timer counts cycles from o_sel. When TIMEOUT_CYCLES cycles pass with no ack, response data is ERR_DATA, o_timeout_cnt increments, and the next state is RESP.
REQ-009 An ack in the same cycle the timeout expires is treated as a success; the counter does not increment.
REQ-010 RESP: cmd_in.ack=1 for exactly one cycle with cmd_in.rdata equal to the captured response; the next state is IDLE. Writes also return the slave's rdata.
REQ-011 Latency: slave ack in cycle k gives cmd_in.ack in cycle k+1. An unmapped access gives cmd_in.ack two cycles after cmd_in.sel.
REQ-012 cmd_in.sel while not in IDLE is ignored; no state or counter changes. Upstream guarantees at most one outstanding command.
REQ-013 A late i_ack arriving after a timeout, while in IDLE, is ignored.
REQ-014 Both counters saturate at 255 and never wrap.
REQ-015 cmd_in.rdata equals 0 whenever cmd_in.ack=0.

Reset
REQ-016 On i_sys_arst assertion, effective immediately: state=IDLE; timer=0; o_sel=0; cmd_in.ack=0; cmd_in.rdata=0; o_rd_wr_n=0; o_byte_addr=0; o_wdata=0; both counters=0; o_busy=0.
REQ-017 Reset mid-transaction abandons that transaction with no ack emitted. The first command after reset deassertion is accepted normally.

Structure
REQ-018 The following belong in a shared package cmd_router_pkg: the FSM state enum (IDLE, WAIT_ACK, RESP), ERR_DATA default, and the port-index function.
REQ-019 The saturating counter is one sub-module, sat_cnt8, instantiated twice.

Verification
REQ-020 Mapped read: cmd_in.sel with byte_addr=24'h20_0010, rd_wr_n=1 -> o_sel=4'b0100 for one cycle with o_byte_addr=20'h0_0010. Port 2 acks 3 cycles later with 32'h1234_5678 -> cmd_in.ack one cycle later with rdata=32'h1234_5678.
REQ-021 Write: byte_addr=24'h00_0004, wdata=32'hCAFE_F00D, rd_wr_n=0 -> o_sel[0] pulses with o_wdata=32'hCAFE_F00D; port 0 ack -> cmd_in.ack one cycle later.
REQ-022 Unmapped access: byte_addr=24'h50_0000 -> no o_sel; cmd_in.ack two cycles after sel with rdata=32'hBAD0_C0DE; o_unmapped_cnt=1.
REQ-023 Timeout: port 1 never acks -> cmd_in.ack with rdata=ERR_DATA after TIMEOUT_CYCLES; o_timeout_cnt=1. A late port-1 ack is ignored. Ack exactly at expiry -> success with the slave's data.
REQ-024 Wrong-port ack and busy sel: while waiting on port 3, i_ack[1]=1 and a new cmd_in.sel -> both ignored; only the port 3 ack completes the transaction.
REQ-025 Reset in WAIT_ACK -> all outputs 0 immediately and no cmd_in.ack. 300 unmapped accesses -> o_unmapped_cnt=255.
